// File: rtl/gpio_atr_irq.sv
// gpio_atr_irq
//   Settings-bus GPIO block. Each output bit follows either one of four ATR
//   values selected by {tx,rx} or a manual value. Inputs are synchronised,
//   optionally debounced, and edge-detected into a sticky, write-1-to-clear
//   interrupt status.
//
//   Optional build macro: GPIO_ATR_IRQ_DEBOUNCE_EN adds a per-bit debounce
//   filter of DEBOUNCE_CYCLES cycles. Without it the filter is a plain wire.
//
// Ports
//   clk, reset_n          block clock, async active-low reset
//   set_stb/addr/data     settings-bus write (BASE..BASE+9)
//   rx, tx                radio state, selects ATR value
//   gpio_in               asynchronous pin inputs
//   gpio_out, gpio_ddr    registered output value and direction (1 = drive)
//   rb_sel, gpio_readback readback select and registered readback
//   irq                   OR of pending status bits
module gpio_atr_irq #(
    parameter int BASE            = 0,
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic             rx,
    input  logic             tx,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_ddr,
    input  logic [1:0]       rb_sel,
    output logic [31:0]      gpio_readback,
    output logic             irq
);

    localparam logic [7:0] BASE_A = 8'(BASE);

    logic [WIDTH-1:0] idle_q, rxv_q, txv_q, fdx_q, ddr_q, mask_q, man_q, ren_q, fen_q;
    logic [WIDTH-1:0] wdat;
    logic [7:0]       off;

    // Offset relative to BASE; anything past 9 falls through the case default.
    assign off  = set_addr - BASE_A;
    assign wdat = set_data[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_q <= '0; rxv_q <= '0; txv_q <= '0; fdx_q <= '0;
            ddr_q  <= '0; mask_q <= '0; man_q <= '0; ren_q <= '0; fen_q <= '0;
        end else if (set_stb) begin
            case (off)
                8'd0: idle_q <= wdat;
                8'd1: rxv_q  <= wdat;
                8'd2: txv_q  <= wdat;
                8'd3: fdx_q  <= wdat;
                8'd4: ddr_q  <= wdat;
                8'd5: mask_q <= wdat;
                8'd6: man_q  <= wdat;
                8'd7: ren_q  <= wdat;
                8'd8: fen_q  <= wdat;
                default: ;
            endcase
        end
    end

    // ---------------- output path ----------------
    logic [WIDTH-1:0] atr_d, gout_d;

    always_comb begin
        atr_d = idle_q;
        case ({tx, rx})
            2'b01:   atr_d = rxv_q;
            2'b10:   atr_d = txv_q;
            2'b11:   atr_d = fdx_q;
            default: atr_d = idle_q;
        endcase
        gout_d = (mask_q & atr_d) | (~mask_q & man_q);
    end

    // ---------------- input path ----------------
    logic [WIDTH-1:0] s1_q, s2_q, f, p_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= gpio_in;
            s2_q <= s1_q;
        end
    end

`ifdef GPIO_ATR_IRQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    // f only follows s2 once s2 has disagreed with it for DEBOUNCE_CYCLES
    // consecutive cycles; any return to agreement restarts the count.
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        logic [CW-1:0] cnt_q;
        logic          fb_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
                fb_q  <= 1'b0;
            end else if (s2_q[i] == fb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                fb_q  <= s2_q[i];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign f[i] = fb_q;
    end
`else
    assign f = s2_q;
`endif

    // ---------------- edge detect / status ----------------
    logic [WIDTH-1:0] clr, status_q, status_d;

    assign clr = (set_stb && off == 8'd9) ? wdat : '0;

    // Sets are OR-ed in after the clear so a same-cycle set wins.
    assign status_d = (status_q & ~clr)
                    | (f & ~p_q & ren_q)
                    | (~f & p_q & fen_q);

    // ---------------- readback ----------------
    logic [31:0] rb_d;

    always_comb begin
        rb_d = '0;
        case (rb_sel)
            2'd0:    rb_d[WIDTH-1:0] = f;
            2'd1:    rb_d[WIDTH-1:0] = gpio_out;
            2'd2:    rb_d[WIDTH-1:0] = status_q;
            default: rb_d[WIDTH-1:0] = ddr_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q           <= '0;
            status_q      <= '0;
            irq           <= 1'b0;
            gpio_out      <= '0;
            gpio_ddr      <= '0;
            gpio_readback <= '0;
        end else begin
            p_q           <= f;
            status_q      <= status_d;
            irq           <= |status_d;
            gpio_out      <= gout_d;
            gpio_ddr      <= ddr_q;
            gpio_readback <= rb_d;
        end
    end

endmodule
